// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared encodings for the EX operand forward path and the hazard FSM.
package fwd_hazard_ctrl_pkg;

  // Bit positions inside the one-hot forward select.
  localparam int FORWARD_NONE             = 0;
  localparam int FORWARD_COLLISION_IN_MEM = 1;
  localparam int FORWARD_COLLISION_IN_WB  = 2;

  // One-hot select values driven into the EX forward muxes.
  localparam logic [2:0] FWD_SEL_NONE = 3'b001;
  localparam logic [2:0] FWD_SEL_MEM  = 3'b010;
  localparam logic [2:0] FWD_SEL_WB   = 3'b100;

  // Hazard FSM state encoding.
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_HOLD   = 2'd2;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_select_logic.sv
// Match-and-priority for one EX source operand. MEM beats WB because it
// holds the younger producer; the result is always strictly one-hot.
module fwd_select_logic
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          ex_valid,
  input  logic          use_rs,
  input  logic [AW-1:0] rs,
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_rd,
  input  logic          wb_valid,
  input  logic          wb_regwrite,
  input  logic [AW-1:0] wb_rd,
  output logic [2:0]    sel
);

  // x0 never forwards; MEM checked first so WB can never co-assert.
  always_comb begin
    sel = FWD_SEL_NONE;
    if (ex_valid && use_rs && (rs != '0)) begin
      if (mem_valid && mem_regwrite && (mem_rd == rs))   sel = FWD_SEL_MEM;
      else if (wb_valid && wb_regwrite && (wb_rd == rs)) sel = FWD_SEL_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// EX operand forward selects plus load-use / freeze / flush sequencing.
// Optional build macro FWD_HAZARD_PERF_CNT_EN adds saturating perf counters.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_ID,
  input  logic                      use_rs1_ID,
  input  logic                      use_rs2_ID,
  input  logic [REG_ADDR_WIDTH-1:0] rd_ID,
  input  logic                      regwrite_ID,
  input  logic                      memread_ID,
  input  logic                      flush_EX,
  input  logic                      mem_busy,
  output logic                      stall_IF_ID,
  output logic                      bubble_ID_EX,
  output logic                      freeze_all,
  output logic [2:0]                forward_detect_EX_rs1,
  output logic [2:0]                forward_detect_EX_rs2
`ifdef FWD_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_loaduse_cnt,
  output logic [31:0]               perf_freeze_cnt,
  output logic [31:0]               perf_flush_cnt
`endif
);

  localparam int AW = REG_ADDR_WIDTH;

  // vld_pipe[0]=EX, [1]=MEM, [2]=WB
  logic [2:0]          vld_pipe;
  logic [1:0][AW-1:0]  ex_rs;
  logic [1:0]          ex_use;
  logic [AW-1:0]       ex_rd, mem_rd, wb_rd;
  logic                ex_rw, ex_mr, mem_rw, mem_mr, wb_rw;
  logic [1:0]          state, state_nxt;
  logic [1:0][2:0]     fwd_sel;
  logic                hazard, flush_act, lu;

  // State and the MEM-stage load flag are kept for debug observability only.
  logic [2:0]          unused_dbg;
  assign unused_dbg = {state, mem_mr};

  // Load in EX whose rd is read by the real instruction waiting in ID.
  assign hazard = vld_pipe[0] && ex_mr && (ex_rd != '0) && valid_ID &&
                  ((use_rs1_ID && (rs1_ID == ex_rd)) ||
                   (use_rs2_ID && (rs2_ID == ex_rd)));

  // Priority: freeze > flush > load-use.
  assign flush_act = !mem_busy && flush_EX;
  assign lu        = !mem_busy && !flush_EX && hazard;

  // Outputs drop to reset values the moment rst_n falls.
  assign stall_IF_ID  = rst_n && lu;
  assign bubble_ID_EX = rst_n && (flush_act || lu);
  assign freeze_all   = rst_n && mem_busy;

  // Next state: MEM_HOLD while busy; one LOAD_STALL cycle after each stall.
  always_comb begin
    state_nxt = ST_RUN;
    if (mem_busy) state_nxt = ST_MEM_HOLD;
    else if (lu)  state_nxt = ST_LOAD_STALL;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Shadow pipeline: advance unless frozen; bubble clears the EX valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      ex_rs    <= '0;
      ex_use   <= '0;
      ex_rd    <= '0;
      ex_rw    <= 1'b0;
      ex_mr    <= 1'b0;
      mem_rd   <= '0;
      mem_rw   <= 1'b0;
      mem_mr   <= 1'b0;
      wb_rd    <= '0;
      wb_rw    <= 1'b0;
    end else if (!mem_busy) begin
      vld_pipe <= {vld_pipe[1:0], valid_ID && !(flush_EX || hazard)};
      ex_rs    <= {rs2_ID, rs1_ID};
      ex_use   <= {use_rs2_ID, use_rs1_ID};
      ex_rd    <= rd_ID;
      ex_rw    <= regwrite_ID;
      ex_mr    <= memread_ID;
      mem_rd   <= ex_rd;
      mem_rw   <= ex_rw;
      mem_mr   <= ex_mr;
      wb_rd    <= mem_rd;
      wb_rw    <= mem_rw;
    end
  end

  // One select unit per source operand.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    fwd_select_logic #(.AW(AW)) u_sel (
      .ex_valid     (vld_pipe[0]),
      .use_rs       (ex_use[g]),
      .rs           (ex_rs[g]),
      .mem_valid    (vld_pipe[1]),
      .mem_regwrite (mem_rw),
      .mem_rd       (mem_rd),
      .wb_valid     (vld_pipe[2]),
      .wb_regwrite  (wb_rw),
      .wb_rd        (wb_rd),
      .sel          (fwd_sel[g])
    );
  end

  assign forward_detect_EX_rs1 = fwd_sel[0];
  assign forward_detect_EX_rs2 = fwd_sel[1];

`ifdef FWD_HAZARD_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loaduse_cnt <= '0;
      perf_freeze_cnt  <= '0;
      perf_flush_cnt   <= '0;
    end else begin
      if (lu && (perf_loaduse_cnt != '1))       perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
      if (mem_busy && (perf_freeze_cnt != '1))  perf_freeze_cnt  <= perf_freeze_cnt + 32'd1;
      if (flush_act && (perf_flush_cnt != '1))  perf_flush_cnt   <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
